// File: rtl/burst_memory.sv
// burst_memory: single-port word memory with a Valid/Ready request port,
// byte-enabled writes and wrapping multi-beat read bursts. After reset the
// array is cleared sequentially, one word per cycle, before requests are taken.
module burst_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Valid,
  output logic                  Ready,
  input  logic                  R_W,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [DATA_W-1:0]     Din,
  input  logic [DATA_W/8-1:0]   Be,
  input  logic [LEN_W-1:0]      Len,
  output logic [DATA_W-1:0]     Dout,
  output logic                  Dout_Valid,
  output logic                  Busy
);

  localparam int          DEPTH = 2**ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [LEN_W-1:0]    cnt, cnt_n;
  logic                clr_we;
  logic                wr_en;
  logic                rd_beat;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign Ready = (state == S_IDLE);
  assign Busy  = (state == S_CLEAR);

  // State, shared clear/burst pointer and beat counter; reset restarts the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_CLEAR;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state decode plus the per-cycle memory strobes.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    clr_we  = 1'b0;
    wr_en   = 1'b0;
    rd_beat = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_n  = ptr + 1'b1;
        if (ptr == '1) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (Valid) begin
          if (R_W) begin
            wr_en = 1'b1;
          end else begin
            ptr_n   = Addr;
            cnt_n   = Len;
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        rd_beat = 1'b1;
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
          ptr_n = ptr + 1'b1;
        end
      end
      default: begin
        state_n = S_CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  // Storage array: zero fill during clear, byte-masked writes when idle.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (Be[i]) mem[Addr][8*i +: 8] <= Din[8*i +: 8];
      end
    end
  end

  // Registered read port; Dout is forced to zero whenever no beat is presented.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Dout       <= '0;
      Dout_Valid <= 1'b0;
    end else if (rd_beat) begin
      Dout       <= mem[ptr];
      Dout_Valid <= 1'b1;
    end else begin
      Dout       <= '0;
      Dout_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory (ADDR_W=8, DATA_W=32, LEN_W=4).
module tb_burst_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        r_w;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [3:0]  len;
  logic        ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_beats [16];

  burst_memory #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
    .Clk(clk), .Reset(rst), .Valid(valid), .Ready(ready), .R_W(r_w),
    .Addr(addr), .Din(din), .Be(be), .Len(len), .Dout(dout),
    .Dout_Valid(dout_valid), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request at a negedge and hold it until it is accepted.
  task automatic issue(input logic rw, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [3:0] l);
    int t = 0;
    valid = 1'b1; r_w = rw; addr = a; din = d; be = b; len = l;
    while (!ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) check("accept_timeout", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Read burst checked against exp_beats[0..l], then the idle gap after it.
  task automatic read_chk(input string tag, input logic [7:0] a, input logic [3:0] l);
    issue(1'b0, a, 32'h0, 4'h0, l);
    check({tag, "_rdy_accept"}, 32'(ready), 32'd0);
    for (int j = 0; j <= int'(l); j++) begin
      @(negedge clk);
      check($sformatf("%s_v%0d", tag, j), 32'(dout_valid), 32'd1);
      check($sformatf("%s_d%0d", tag, j), dout, exp_beats[j]);
      check($sformatf("%s_rdy%0d", tag, j), 32'(ready), 32'(j == int'(l)));
    end
    @(negedge clk);
    check({tag, "_gap_v"}, 32'(dout_valid), 32'd0);
    check({tag, "_gap_d"}, dout, 32'h0);
  endtask

  // Called on the negedge where reset is released; counts busy cycles.
  task automatic wait_clear(input string tag);
    int   cyc = 0;
    logic bad = 1'b0;
    while (busy && cyc < 400) begin
      if (ready || dout_valid) bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 32'(cyc), 32'd256);
    check({tag, "_quiet"}, 32'(bad), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_ready_high"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; r_w = 1'b0; addr = '0; din = '0; be = '0; len = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dv", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_clear("clr1");

    // Cleared array reads back zero over a full 16-beat burst.
    for (int i = 0; i < 16; i++) exp_beats[i] = 32'h0;
    read_chk("clr_rd", 8'h00, 4'd15);

    // Byte enables; the read is accepted on the edge right after the write.
    issue(1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 4'd0);
    issue(1'b1, 8'h10, 32'h11223344, 4'b0101, 4'd0);
    exp_beats[0] = 32'hAA22CC44;
    read_chk("be", 8'h10, 4'd0);

    // Burst wrapping from 0xFF to 0x00.
    issue(1'b1, 8'hFE, 32'd1, 4'hF, 4'd0);
    issue(1'b1, 8'hFF, 32'd2, 4'hF, 4'd0);
    issue(1'b1, 8'h00, 32'd3, 4'hF, 4'd0);
    issue(1'b1, 8'h01, 32'd4, 4'hF, 4'd0);
    exp_beats[0] = 32'd1; exp_beats[1] = 32'd2; exp_beats[2] = 32'd3; exp_beats[3] = 32'd4;
    read_chk("wrap", 8'hFE, 4'd3);

    // Backpressure: a write held on Valid during a Len=7 burst.
    for (int i = 0; i < 8; i++) issue(1'b1, 8'(8'h30 + i), 32'(32'h100 + i), 4'hF, 4'd0);
    issue(1'b1, 8'h20, 32'h00000055, 4'hF, 4'd0);
    exp_beats[0] = 32'h00000055;
    read_chk("bp_pre", 8'h20, 4'd0);
    issue(1'b0, 8'h30, 32'h0, 4'h0, 4'd7);
    valid = 1'b1; r_w = 1'b1; addr = 8'h20; din = 32'hCAFEF00D; be = 4'hF;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("bp_v%0d", j), 32'(dout_valid), 32'd1);
      check($sformatf("bp_d%0d", j), dout, 32'(32'h100 + j));
      check($sformatf("bp_rdy%0d", j), 32'(ready), 32'(j == 7));
    end
    @(negedge clk);
    valid = 1'b0;
    check("bp_after_v", 32'(dout_valid), 32'd0);
    check("bp_after_rdy", 32'(ready), 32'd1);
    exp_beats[0] = 32'hCAFEF00D;
    read_chk("bp_rd", 8'h20, 4'd0);

    // Back-to-back Len=1 reads with Valid held high.
    issue(1'b1, 8'h40, 32'hA0A0A0A0, 4'hF, 4'd0);
    issue(1'b1, 8'h41, 32'hB1B1B1B1, 4'hF, 4'd0);
    issue(1'b1, 8'h42, 32'hC2C2C2C2, 4'hF, 4'd0);
    issue(1'b1, 8'h43, 32'hD3D3D3D3, 4'hF, 4'd0);
    valid = 1'b1; r_w = 1'b0; addr = 8'h40; len = 4'd1;
    @(negedge clk);
    check("b2b_k0_v", 32'(dout_valid), 32'd0);
    addr = 8'h42;
    @(negedge clk);
    check("b2b_k1_v", 32'(dout_valid), 32'd1);
    check("b2b_k1_d", dout, 32'hA0A0A0A0);
    @(negedge clk);
    check("b2b_k2_v", 32'(dout_valid), 32'd1);
    check("b2b_k2_d", dout, 32'hB1B1B1B1);
    @(negedge clk);
    check("b2b_k3_v", 32'(dout_valid), 32'd0);
    check("b2b_k3_d", dout, 32'h0);
    check("b2b_k3_rdy", 32'(ready), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    check("b2b_k4_v", 32'(dout_valid), 32'd1);
    check("b2b_k4_d", dout, 32'hC2C2C2C2);
    @(negedge clk);
    check("b2b_k5_v", 32'(dout_valid), 32'd1);
    check("b2b_k5_d", dout, 32'hD3D3D3D3);
    @(negedge clk);
    check("b2b_k6_v", 32'(dout_valid), 32'd0);

    // Reset on beat 2 of a Len=15 burst.
    issue(1'b1, 8'h50, 32'h12345678, 4'hF, 4'd0);
    issue(1'b0, 8'h40, 32'h0, 4'h0, 4'd15);
    @(negedge clk);
    check("rb_d0", dout, 32'hA0A0A0A0);
    @(negedge clk);
    check("rb_d1", dout, 32'hB1B1B1B1);
    @(negedge clk);
    check("rb_d2", dout, 32'hC2C2C2C2);
    rst = 1'b1;
    #1;
    check("rb_v_now", 32'(dout_valid), 32'd0);
    check("rb_d_now", dout, 32'h0);
    check("rb_busy", 32'(busy), 32'd1);
    check("rb_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    check("rb_hold_v", 32'(dout_valid), 32'd0);
    rst = 1'b0;
    wait_clear("clr2");

    for (int i = 0; i < 16; i++) exp_beats[i] = 32'h0;
    read_chk("post_10", 8'h10, 4'd0);
    read_chk("post_20", 8'h20, 4'd0);
    read_chk("post_40", 8'h40, 4'd3);
    read_chk("post_50", 8'h50, 4'd0);
    read_chk("post_fe", 8'hFE, 4'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
